// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I constants and the fetch prefetch slot type
package rv32i_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef enum logic [1:0] {SLOT_FREE, SLOT_PENDING, SLOT_FILLED} slot_state_t;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    slot_state_t state;
  } fetch_slot_t;
endpackage

// File: rtl/fetch_slot_queue.sv
// fetch_slot_queue: in-order prefetch slots with separate pop, fill and allocate pointers
module fetch_slot_queue
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            alloc,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            fill,
  input  logic [XLEN-1:0] fill_data,
  input  logic            pop,
  output logic            head_valid,
  output logic [XLEN-1:0] head_pc,
  output logic [XLEN-1:0] head_instr,
  output logic [PTR_W:0]  occupancy
);
  fetch_slot_t slots [DEPTH];
  logic [PTR_W-1:0] head, fill_ptr, tail;
  logic fill_ok;
  assign fill_ok = fill && slots[fill_ptr].state == SLOT_PENDING;
  assign head_valid = slots[head].state == SLOT_FILLED;
  assign head_pc = slots[head].pc;
  assign head_instr = slots[head].instr;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head <= '0;
      fill_ptr <= '0;
      tail <= '0;
      occupancy <= '0;
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
    end else begin
      if (alloc) tail <= tail + 1'b1;
      if (fill_ok) fill_ptr <= fill_ptr + 1'b1;
      if (pop) head <= head + 1'b1;
      occupancy <= occupancy + (PTR_W+1)'(alloc) - (PTR_W+1)'(pop);
      // alloc, fill and pop always target slots in distinct states, so at most one fires per slot
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc && tail == PTR_W'(i)) slots[i] <= '{pc: alloc_pc, instr: NOP_INSTR, state: SLOT_PENDING};
        else if (fill_ok && fill_ptr == PTR_W'(i)) begin
          slots[i].instr <= fill_data;
          slots[i].state <= SLOT_FILLED;
        end else if (pop && head == PTR_W'(i)) slots[i].state <= SLOT_FREE;
      end
    end
  end
  always_ff @(posedge clk) if (!rst) assert (occupancy <= (PTR_W+1)'(DEPTH));
endmodule

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: PC owner issuing in-order imem requests into a prefetch queue, with redirect flush
module fetch_prefetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            pc_sel,
  input  logic [XLEN-1:0] pc_nxt,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic [XLEN-1:0] pc_f,
  output logic [XLEN-1:0] instruction,
  output logic            valid_f
);
  logic [XLEN-1:0] fetch_pc, head_pc, head_instr;
  logic [PTR_W:0] inflight, inflight_next, drop_cnt, occupancy;
  logic accept, drop, head_valid;
  assign imem_req_valid = !rst && !pc_sel && occupancy < (PTR_W+1)'(DEPTH);
  assign imem_req_addr = fetch_pc;
  assign accept = imem_req_valid && imem_req_ready;
  assign drop = drop_cnt != '0;
  assign inflight_next = inflight + (PTR_W+1)'(accept) - (PTR_W+1)'(imem_resp_valid);
  assign valid_f = head_valid;
  assign pc_f = head_valid ? head_pc : '0;
  assign instruction = head_valid ? head_instr : NOP_INSTR;
  fetch_slot_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_queue (
    .clk(clk),
    .rst(rst),
    .flush(pc_sel),
    .alloc(accept),
    .alloc_pc(fetch_pc),
    .fill(imem_resp_valid && !drop && !pc_sel),
    .fill_data(imem_resp_data),
    .pop(head_valid && !stall && !pc_sel),
    .head_valid(head_valid),
    .head_pc(head_pc),
    .head_instr(head_instr),
    .occupancy(occupancy)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight_next;
      // every request still outstanding after a redirect belongs to the old path
      if (pc_sel) begin
        fetch_pc <= pc_nxt & ~XLEN'(3);
        drop_cnt <= inflight_next;
      end else begin
        if (accept) fetch_pc <= fetch_pc + XLEN'(4);
        if (imem_resp_valid && drop) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (inflight <= (PTR_W+1)'(DEPTH));
      assert (!(imem_resp_valid && inflight == '0));
      assert (drop_cnt <= inflight);
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: scenario and randomized checks against an epoch-tagged queue model
module tb_fetch_prefetch_unit;
  import rv32i_pkg::*;
  localparam int DEPTH = 4;
  typedef struct {logic [31:0] pc; bit filled; logic [31:0] data;} ent_t;
  typedef struct {logic [31:0] addr; int due; int ep;} mreq_t;
  logic clk = 0, rst = 1, stall = 0, pc_sel = 0, imem_req_ready = 1, imem_resp_valid = 0;
  logic [31:0] pc_nxt = '0, imem_resp_data = '0;
  logic imem_req_valid, valid_f;
  logic [31:0] imem_req_addr, pc_f, instruction;
  ent_t q[$];
  mreq_t mq[$];
  logic [31:0] m_pc = '0, last_acc = '0;
  int epoch = 0, cyc = 0, lat = 1, checks = 0, passes = 0;
  logic s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_ins;
  always #5 clk = ~clk;
  fetch_prefetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk(clk), .rst(rst), .stall(stall), .pc_sel(pc_sel), .pc_nxt(pc_nxt),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .pc_f(pc_f), .instruction(instruction), .valid_f(valid_f)
  );
  // one clock: memory drives its response, outputs are compared before the edge, the model advances at the edge
  task automatic step();
    bit resp, e_req, e_vf, acc, done;
    logic [31:0] e_pc, e_ins;
    mreq_t r;
    resp = !rst && mq.size() > 0 && mq[0].due <= cyc;
    imem_resp_valid = resp;
    imem_resp_data = resp ? (mq[0].addr | 32'hA000) : 32'hDEAD_BEEF;
    @(negedge clk);
    s_req = imem_req_valid; s_addr = imem_req_addr; s_valid = valid_f; s_pc = pc_f; s_ins = instruction;
    e_req = !rst && !pc_sel && q.size() < DEPTH;
    e_vf = q.size() > 0 && q[0].filled;
    e_pc = e_vf ? q[0].pc : 32'h0;
    e_ins = e_vf ? q[0].data : NOP_INSTR;
    checks++;
    if (s_req !== e_req) $display("FAIL req_valid cyc=%0d got %b exp %b", cyc, s_req, e_req); else passes++;
    if (e_req) begin
      checks++;
      if (s_addr !== m_pc) $display("FAIL req_addr cyc=%0d got %h exp %h", cyc, s_addr, m_pc); else passes++;
    end
    if (!rst) begin
      checks += 3;
      if (s_valid !== e_vf) $display("FAIL valid_f cyc=%0d got %b exp %b", cyc, s_valid, e_vf); else passes++;
      if (s_pc !== e_pc) $display("FAIL pc_f cyc=%0d got %h exp %h", cyc, s_pc, e_pc); else passes++;
      if (s_ins !== e_ins) $display("FAIL instruction cyc=%0d got %h exp %h", cyc, s_ins, e_ins); else passes++;
    end
    acc = e_req && imem_req_ready;
    @(posedge clk);
    if (rst) begin
      q.delete(); mq.delete(); m_pc = 32'h0; epoch++;
    end else if (pc_sel) begin
      q.delete();
      if (resp) mq.delete(0);
      m_pc = pc_nxt & ~32'h3;
      epoch++;
    end else begin
      if (e_vf && !stall) q.delete(0);
      if (resp) begin
        r = mq[0];
        mq.delete(0);
        done = 0;
        if (r.ep == epoch)
          foreach (q[k]) if (!done && !q[k].filled) begin q[k].filled = 1; q[k].data = r.addr | 32'hA000; done = 1; end
      end
      if (acc) begin
        q.push_back('{pc: m_pc, filled: 0, data: 32'h0});
        mq.push_back('{addr: m_pc, due: cyc + lat, ep: epoch});
        last_acc = m_pc;
        m_pc += 32'd4;
      end
    end
    cyc++;
    #1;
  endtask
  task automatic do_reset();
    rst = 1; pc_sel = 0; stall = 0; imem_req_ready = 1;
    step(); step();
    rst = 0;
  endtask
  task automatic test_reset();
    do_reset();
    step();
    checks += 5;
    if (s_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", s_valid); else passes++;
    if (s_pc !== 32'h0) $display("FAIL reset_pc got %h exp 0", s_pc); else passes++;
    if (s_ins !== 32'h13) $display("FAIL reset_nop got %h exp 00000013", s_ins); else passes++;
    if (s_req !== 1'b1) $display("FAIL reset_req got %b exp 1", s_req); else passes++;
    if (s_addr !== 32'h0) $display("FAIL reset_addr got %h exp 0", s_addr); else passes++;
  endtask
  task automatic test_stream();
    logic [31:0] ep;
    lat = 1;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step();
      ep = 32'((i - 2) * 4);
      checks++;
      if (i < 2) begin
        if (s_valid !== 1'b0) $display("FAIL stream_early i=%0d got valid %b exp 0", i, s_valid); else passes++;
      end else if (s_valid !== 1'b1 || s_pc !== ep || s_ins !== (ep | 32'hA000))
        $display("FAIL stream i=%0d got %b/%h/%h exp 1/%h/%h", i, s_valid, s_pc, s_ins, ep, ep | 32'hA000);
      else passes++;
    end
  endtask
  task automatic test_stall();
    lat = 1;
    do_reset();
    for (int i = 0; i < 4; i++) step();
    stall = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (s_valid !== 1'b1 || s_pc !== 32'h8 || s_ins !== 32'hA008)
        $display("FAIL stall_hold i=%0d got %b/%h/%h exp 1/8/a008", i, s_valid, s_pc, s_ins);
      else passes++;
    end
    checks += 2;
    if (last_acc !== 32'h14) $display("FAIL stall_last_req got %h exp 14", last_acc); else passes++;
    if (s_req !== 1'b0) $display("FAIL stall_full_req got %b exp 0", s_req); else passes++;
    stall = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (s_valid !== 1'b1 || s_pc !== 32'(8 + 4 * i)) $display("FAIL stall_release i=%0d got %b/%h exp 1/%h", i, s_valid, s_pc, 8 + 4 * i);
      else passes++;
    end
  endtask
  task automatic test_redirect();
    logic [31:0] first;
    bit found;
    lat = 3;
    do_reset();
    step(); step();
    pc_sel = 1; pc_nxt = 32'h100;
    step();
    pc_sel = 0;
    found = 0; first = '0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (s_valid && !found) begin first = s_pc; found = 1; end
    end
    checks++;
    if (!found || first !== 32'h100) $display("FAIL redirect_first got %b/%h exp 1/100", found, first); else passes++;
  endtask
  task automatic test_same_cycle();
    logic [31:0] first;
    bit found;
    lat = 2;
    do_reset();
    step(); step();
    pc_sel = 1; pc_nxt = 32'h200;
    step();
    pc_sel = 0;
    checks++;
    if (dut.drop_cnt !== 3'd1) $display("FAIL same_cycle_drop got %0d exp 1", dut.drop_cnt); else passes++;
    found = 0; first = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (s_valid && !found) begin first = s_pc; found = 1; end
    end
    checks++;
    if (!found || first !== 32'h200) $display("FAIL same_cycle_first got %b/%h exp 1/200", found, first); else passes++;
  endtask
  task automatic test_misaligned_and_ready();
    lat = 1;
    pc_sel = 1; pc_nxt = 32'h103;
    step();
    pc_sel = 0;
    step();
    checks++;
    if (s_req !== 1'b1 || s_addr !== 32'h100) $display("FAIL misaligned got %b/%h exp 1/100", s_req, s_addr); else passes++;
    step(); step();
    imem_req_ready = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (s_req !== 1'b1 || s_addr !== 32'h10C) $display("FAIL ready_low i=%0d got %b/%h exp 1/10c", i, s_req, s_addr); else passes++;
    end
    imem_req_ready = 1;
    step(); step();
    rst = 1;
    step();
    rst = 0;
    step();
    checks++;
    if (s_valid !== 1'b0 || s_ins !== 32'h13 || s_pc !== 32'h0 || s_req !== 1'b1 || s_addr !== 32'h0)
      $display("FAIL mid_reset got %b/%h/%h/%b/%h exp 0/13/0/1/0", s_valid, s_ins, s_pc, s_req, s_addr);
    else passes++;
  endtask
  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      stall = $urandom_range(0, 9) < 3;
      pc_sel = $urandom_range(0, 19) == 0;
      pc_nxt = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFF9 : $urandom;
      imem_req_ready = $urandom_range(0, 3) != 0;
      lat = $urandom_range(1, 4);
      step();
    end
    pc_sel = 0; stall = 0; imem_req_ready = 1;
  endtask
  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_same_cycle();
    test_misaligned_and_ready();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
